// File: rtl/fifo_uart_pkg.sv
// ============================================================================
//  Module      : fifo_uart_pkg
//  Description : Shared definitions for the FIFO-draining UART transmitter.
//                Holds the 3-bit state encoding and the idle line level.
//                The PARITY encoding is always reserved. It is only reached
//                when FIFO_UART_TX_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  // Level driven on the serial line whenever no frame is in flight
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LOAD   = ST_LOAD,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_uart_tx_if.sv
// ============================================================================
//  Module      : fifo_uart_tx_if
//  Description : Read-side handshake between a synchronous FIFO and its
//                consumer.
//                  fifo_empty - FIFO empty flag
//                  fifo_data  - registered read data, valid the cycle after
//                               fifo_rd_en
//                  fifo_rd_en - single-cycle read strobe
//                master : the consumer, which drives the read strobe
//                slave  : the FIFO
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 4
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en
  );

endinterface

`default_nettype wire

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// ============================================================================
//  Module      : baud_tick_gen
//  Description : Bit-period counter for the serialiser.
//                The counter runs 0..CLKS_PER_BIT-1 and wraps at every bit
//                boundary.
//  Ports       : clk      - rising-edge clock
//                rst_n    - asynchronous active-low reset
//                clear    - synchronous clear; holds the counter at 0
//                tick     - high on the last cycle of a bit period
//                pre_tick - high on the second-to-last cycle of a bit period
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int            CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == C_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // pre_tick lets the parent register a pulse that coincides with tick
  assign tick     = !clear && (r_cnt == C_LAST);
  assign pre_tick = !clear && (r_cnt == C_PRE);

endmodule

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : Drains a synchronous FIFO and serialises each word onto a
//                UART-style, LSB-first line.
//                Frame layout: start(0), DATA_WIDTH data bits, optional even
//                parity bit, stop(1). Each bit lasts CLKS_PER_BIT cycles.
//                Optional feature macro: FIFO_UART_TX_PARITY_EN
//  Ports       : clk        - rising-edge clock
//                rst_n      - asynchronous active-low reset
//                enable     - permits starting a new frame
//                fifo       - FIFO read interface (master side)
//                tx         - serial line, idle high
//                busy       - frame in progress (from read strobe to stop end)
//                frame_done - one-cycle pulse on the last stop-bit cycle
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  fifo_uart_tx_if.master    fifo,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int            BW         = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] C_LAST_BIT = BW'(DATA_WIDTH - 1);

  state_t                r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic [BW-1:0]         r_bit_cnt, w_bit_cnt_next;
  logic                  r_rd_en, w_rd_en_next;
  logic                  w_tx_next, w_busy_next, w_done_next;
  logic                  w_start_ok, w_baud_clear, w_tick, w_pre_tick;

`ifdef FIFO_UART_TX_PARITY_EN
  logic                  r_parity, w_parity_next;
`endif

  assign w_start_ok   = enable && !fifo.fifo_empty;
  // Baud counter is held at zero until the start bit begins
  assign w_baud_clear = (r_state == S_IDLE) || (r_state == S_LOAD);

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_baud_clear),
    .tick     (w_tick),
    .pre_tick (w_pre_tick)
  );

  // Outputs are registered from next-state values, so each output changes
  // together with the state it belongs to.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_rd_en_next   = 1'b0;
    w_tx_next      = tx;
    w_busy_next    = busy;
    w_done_next    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    w_parity_next  = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        w_tx_next = IDLE_LEVEL;
        if (r_rd_en) begin
          // The strobe is out this cycle. The word arrives next cycle in LOAD.
          w_state_next = S_LOAD;
          w_busy_next  = 1'b1;
        end else if (w_start_ok) begin
          w_rd_en_next = 1'b1;
          w_busy_next  = 1'b1;
        end else begin
          w_busy_next  = 1'b0;
        end
      end
      S_LOAD: begin
        w_shift_next   = fifo.fifo_data;
        w_bit_cnt_next = '0;
        w_tx_next      = 1'b0;
        w_state_next   = S_START;
`ifdef FIFO_UART_TX_PARITY_EN
        w_parity_next  = ^fifo.fifo_data;
`endif
      end
      S_START: begin
        w_tx_next = 1'b0;
        if (w_tick) begin
          w_state_next = S_DATA;
          w_tx_next    = r_shift[0];
        end
      end
      S_DATA: begin
        w_tx_next = r_shift[0];
        if (w_tick) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_cnt == C_LAST_BIT) begin
            w_bit_cnt_next = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            w_state_next   = S_PARITY;
            w_tx_next      = r_parity;
`else
            w_state_next   = S_STOP;
            w_tx_next      = IDLE_LEVEL;
`endif
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
            w_tx_next      = w_shift_next[0];
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        w_tx_next = r_parity;
        if (w_tick) begin
          w_state_next = S_STOP;
          w_tx_next    = IDLE_LEVEL;
        end
      end
`endif
      S_STOP: begin
        w_tx_next   = IDLE_LEVEL;
        w_done_next = w_pre_tick;
        if (w_tick) begin
          w_state_next = S_IDLE;
          // The next read is issued here, so IDLE lasts a single cycle
          // between back-to-back frames.
          if (w_start_ok) begin
            w_rd_en_next = 1'b1;
            w_busy_next  = 1'b1;
          end else begin
            w_busy_next  = 1'b0;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = IDLE_LEVEL;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_rd_en    <= 1'b0;
      tx         <= IDLE_LEVEL;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_rd_en    <= w_rd_en_next;
      tx         <= w_tx_next;
      busy       <= w_busy_next;
      frame_done <= w_done_next;
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= w_parity_next;
    end
  end
`endif

  assign fifo.fifo_rd_en = r_rd_en;

endmodule

`default_nettype wire
